weight_loader_banked: RTL and testbench

Parametrised weight store for the LeNet accelerator. It is filled over a valid/ready byte stream from the AXI4-Lite register bank and tracks per-layer fill status. Weights are read through a multi-lane, layer-addressed read port with one cycle of latency, instead of being exposed as a fully flattened bus. It sits between the AXI slave write path and the conv/FC engines, and replaces the single-region weight buffer for designs with more layers or wider datapaths.

---
 rtl/lenet_weight_pkg.sv | 50 +++++
 rtl/weight_lane_mux.sv | 41 ++++
 rtl/weight_loader_banked.sv | 141 ++++++++++++++
 tb/tb_weight_loader_banked.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_weight_pkg.sv
// Shared constants, region-table helpers and FSM encoding for the LeNet weight store.
package lenet_weight_pkg;

  localparam int unsigned BW         = 8;
  localparam int unsigned MAX_LAYERS = 8;

  localparam int unsigned L0_SIZE = 150;
  localparam int unsigned L1_SIZE = 2400;
  localparam int unsigned L2_SIZE = 670;

  localparam int unsigned L0_BASE     = 0;
  localparam int unsigned L1_BASE     = L0_BASE + L0_SIZE;
  localparam int unsigned L2_BASE     = L1_BASE + L1_SIZE;
  localparam int unsigned TOTAL_WORDS = L2_BASE + L2_SIZE;

  typedef enum logic [1:0] {StEmpty, StLoad, StFull} wl_state_e;

  // Bits needed to index 'value' distinct items; never less than 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    bits = 1;
    while ((32'd1 << bits) < value) bits++;
    return bits;
  endfunction

  function automatic int unsigned region_size(input logic [MAX_LAYERS*32-1:0] sizes,
                                              input int unsigned n);
    return sizes[n*32 +: 32];
  endfunction

  function automatic int unsigned region_base(input logic [MAX_LAYERS*32-1:0] sizes,
                                              input int unsigned n);
    int unsigned base;
    base = 0;
    for (int unsigned i = 0; i < MAX_LAYERS; i++) begin
      if (i < n) base += sizes[i*32 +: 32];
    end
    return base;
  endfunction

  function automatic int unsigned region_max(input logic [MAX_LAYERS*32-1:0] sizes);
    int unsigned m;
    m = 1;
    for (int unsigned i = 0; i < MAX_LAYERS; i++) begin
      if (sizes[i*32 +: 32] > m) m = sizes[i*32 +: 32];
    end
    return m;
  endfunction

endpackage

// File: rtl/weight_lane_mux.sv
// Per-lane flat array index generation with region bounds and layer-ready gating.
module weight_lane_mux
  import lenet_weight_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 3,
  parameter int unsigned LANES      = 4,
  parameter int unsigned AW         = 12,
  parameter int unsigned IW         = 12,
  parameter logic [MAX_LAYERS*32-1:0] SIZE_VEC = '0
) (
  input  logic [2:0]                 rd_layer,
  input  logic [AW-1:0]              rd_addr,
  input  logic [NUM_LAYERS-1:0]      layer_ready,
  output logic [LANES-1:0][IW-1:0]   lane_idx,
  output logic [LANES-1:0]           lane_ok
);

  logic [MAX_LAYERS-1:0] ready_ext;
  logic                  layer_ok;
  int unsigned           sel_base;
  int unsigned           sel_size;
  int unsigned           offset;

  always_comb begin
    ready_ext = '0;
    ready_ext[NUM_LAYERS-1:0] = layer_ready;
    sel_base = region_base(SIZE_VEC, 32'(rd_layer));
    sel_size = region_size(SIZE_VEC, 32'(rd_layer));
    layer_ok = (32'(rd_layer) < NUM_LAYERS) && ready_ext[rd_layer];
    offset   = 0;
    lane_idx = '0;
    lane_ok  = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      offset     = 32'(rd_addr) + k;
      lane_ok[k] = layer_ok && (offset < sel_size);
      // Park rejected lanes at index 0 so the array is never addressed out of range.
      if (lane_ok[k]) lane_idx[k] = IW'(sel_base + offset);
    end
  end

endmodule

// File: rtl/weight_loader_banked.sv
// Banked weight store: stream-filled flat array with per-layer ready flags and a
// registered multi-lane read port.
module weight_loader_banked
  import lenet_weight_pkg::*;
#(
  parameter int unsigned BW         = lenet_weight_pkg::BW,
  parameter int unsigned NUM_LAYERS = 3,
  parameter int unsigned L0_SIZE    = lenet_weight_pkg::L0_SIZE,
  parameter int unsigned L1_SIZE    = lenet_weight_pkg::L1_SIZE,
  parameter int unsigned L2_SIZE    = lenet_weight_pkg::L2_SIZE,
  parameter int unsigned L3_SIZE    = 0,
  parameter int unsigned L4_SIZE    = 0,
  parameter int unsigned L5_SIZE    = 0,
  parameter int unsigned L6_SIZE    = 0,
  parameter int unsigned L7_SIZE    = 0,
  parameter int unsigned LANES      = 4,
  localparam logic [MAX_LAYERS*32-1:0] SIZE_VEC = {32'(L7_SIZE), 32'(L6_SIZE), 32'(L5_SIZE),
                                                   32'(L4_SIZE), 32'(L3_SIZE), 32'(L2_SIZE),
                                                   32'(L1_SIZE), 32'(L0_SIZE)},
  localparam int unsigned AW = clog2(region_max(SIZE_VEC))
) (
  input  logic                   clk,
  input  logic                   global_rst_n,
  input  logic                   ce,
  input  logic                   user_reset,
  input  logic                   s_valid,
  input  logic signed [BW-1:0]   s_data,
  output logic                   s_ready,
  input  logic                   rd_en,
  input  logic [2:0]             rd_layer,
  input  logic [AW-1:0]          rd_addr,
  output logic [LANES*BW-1:0]    rd_data,
  output logic                   rd_valid,
  output logic [NUM_LAYERS-1:0]  layer_ready,
  output logic                   o_empty,
  output logic                   o_full,
  output logic                   o_ovf
);

  localparam int unsigned TOTAL = region_base(SIZE_VEC, MAX_LAYERS);
  localparam int unsigned WPW   = clog2(TOTAL + 1);
  localparam int unsigned IW    = clog2(TOTAL);

  logic [BW-1:0] mem [TOTAL];

  wl_state_e               state_q, state_d;
  logic [WPW-1:0]          wp_q, wp_d, wp_inc;
  logic [NUM_LAYERS-1:0]   ready_q, ready_d;
  logic                    ovf_q, ovf_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [LANES*BW-1:0]     rd_data_q, rd_data_d, rd_word;
  logic                    accept;

  logic [LANES-1:0][IW-1:0] lane_idx;
  logic [LANES-1:0]         lane_ok;

  weight_lane_mux #(
    .NUM_LAYERS (NUM_LAYERS),
    .LANES      (LANES),
    .AW         (AW),
    .IW         (IW),
    .SIZE_VEC   (SIZE_VEC)
  ) u_lane_mux (
    .rd_layer    (rd_layer),
    .rd_addr     (rd_addr),
    .layer_ready (ready_q),
    .lane_idx    (lane_idx),
    .lane_ok     (lane_ok)
  );

  assign s_ready = (state_q != StFull);
  assign accept  = ce & s_valid & s_ready;
  assign wp_inc  = wp_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q;
    ready_d    = ready_q;
    ovf_d      = ovf_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_word    = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      rd_word[k*BW +: BW] = lane_ok[k] ? mem[lane_idx[k]] : '0;
    end
    if (ce) begin
      if (user_reset) begin
        state_d    = StEmpty;
        wp_d       = '0;
        ready_d    = '0;
        ovf_d      = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = '0;
      end else begin
        if (accept) begin
          wp_d    = wp_inc;
          state_d = (wp_inc == WPW'(TOTAL)) ? StFull : StLoad;
          for (int unsigned n = 0; n < NUM_LAYERS; n++) begin
            if (wp_inc == WPW'(region_base(SIZE_VEC, n) + region_size(SIZE_VEC, n))) begin
              ready_d[n] = 1'b1;
            end
          end
        end
        if (s_valid && (state_q == StFull)) ovf_d = 1'b1;
        rd_valid_d = rd_en;
        if (rd_en) rd_data_d = rd_word;
      end
    end
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_q    <= StEmpty;
      wp_q       <= '0;
      ready_q    <= '0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      ready_q    <= ready_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Contents survive clears; layer-ready gating hides stale words.
  always_ff @(posedge clk) begin
    if (accept && !user_reset) mem[wp_q[IW-1:0]] <= s_data;
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign layer_ready = ready_q;
  assign o_empty     = (state_q == StEmpty);
  assign o_full      = (state_q == StFull);
  assign o_ovf       = ovf_q;

endmodule

// File: tb/tb_weight_loader_banked.sv
// Directed bench for weight_loader_banked with default 150/2400/670 regions and 4 lanes.
module tb_weight_loader_banked;

  logic              clk = 1'b0;
  logic              global_rst_n;
  logic              ce;
  logic              user_reset;
  logic              s_valid;
  logic signed [7:0] s_data;
  logic              s_ready;
  logic              rd_en;
  logic [2:0]        rd_layer;
  logic [11:0]       rd_addr;
  logic [31:0]       rd_data;
  logic              rd_valid;
  logic [2:0]        layer_ready;
  logic              o_empty;
  logic              o_full;
  logic              o_ovf;

  int checks = 0;
  int errors = 0;

  weight_loader_banked dut (
    .clk          (clk),
    .global_rst_n (global_rst_n),
    .ce           (ce),
    .user_reset   (user_reset),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .rd_en        (rd_en),
    .rd_layer     (rd_layer),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .layer_ready  (layer_ready),
    .o_empty      (o_empty),
    .o_full       (o_full),
    .o_ovf        (o_ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Data pattern of the first full load: region 0 is i mod 128, the rest a scramble.
  function automatic logic [7:0] fval(input int g);
    if (g < 150) return 8'(g % 128);
    return 8'((g * 5 + 1) & 255);
  endfunction

  task automatic do_read(input logic [2:0] layer, input logic [11:0] addr);
    rd_en    = 1'b1;
    rd_layer = layer;
    rd_addr  = addr;
    step();
    rd_en    = 1'b0;
  endtask

  initial begin
    global_rst_n = 1'b0;
    ce           = 1'b1;
    user_reset   = 1'b0;
    s_valid      = 1'b0;
    s_data       = '0;
    rd_en        = 1'b0;
    rd_layer     = '0;
    rd_addr      = '0;
    repeat (2) step();
    global_rst_n = 1'b1;
    step();

    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_empty", 32'(o_empty), 32'd1);
    check("rst_full", 32'(o_full), 32'd0);
    check("rst_ovf", 32'(o_ovf), 32'd0);
    check("rst_layer_ready", 32'(layer_ready), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);

    do_read(3'd0, 12'd0);
    check("empty_read_valid", 32'(rd_valid), 32'd1);
    check("empty_read_data", rd_data, 32'd0);
    step();
    check("read_pulse_single", 32'(rd_valid), 32'd0);

    // Region 0, with a same-cycle read on the completing word.
    for (int g = 0; g < 150; g++) begin
      s_valid = 1'b1;
      s_data  = fval(g);
      if (g == 149) begin
        rd_en    = 1'b1;
        rd_layer = 3'd0;
        rd_addr  = 12'd148;
      end
      step();
      rd_en = 1'b0;
      if (g == 148) check("l0_not_ready_early", 32'(layer_ready), 32'd0);
      if (g == 149) begin
        check("l0_ready", 32'(layer_ready), 32'b001);
        check("read_during_fill", rd_data, 32'd0);
        check("not_empty", 32'(o_empty), 32'd0);
      end
    end
    s_valid = 1'b0;

    do_read(3'd0, 12'd148);
    check("l0_addr148", rd_data, 32'h0000_1514);
    do_read(3'd0, 12'd0);
    check("l0_addr0", rd_data, 32'h0302_0100);

    // Remaining regions with random idle gaps.
    for (int g = 150; g < 3220; g++) begin
      s_valid = 1'b0;
      repeat ($urandom_range(0, 2)) step();
      s_valid = 1'b1;
      s_data  = fval(g);
      if (g == 1350) begin
        rd_en    = 1'b1;
        rd_layer = 3'd1;
        rd_addr  = 12'd0;
      end
      step();
      s_valid = 1'b0;
      rd_en   = 1'b0;
      if (g == 1350) begin
        check("l1_half_valid", 32'(rd_valid), 32'd1);
        check("l1_half_data", rd_data, 32'd0);
        check("l1_half_ready", 32'(layer_ready), 32'b001);
      end
      if (g == 2549) check("l1_ready", 32'(layer_ready), 32'b011);
      if (g == 3218) begin
        check("pre_full_ready", 32'(s_ready), 32'd1);
        check("pre_full_full", 32'(o_full), 32'd0);
      end
    end

    check("full", 32'(o_full), 32'd1);
    check("full_s_ready", 32'(s_ready), 32'd0);
    check("all_ready", 32'(layer_ready), 32'b111);
    check("full_ovf_clear", 32'(o_ovf), 32'd0);

    do_read(3'd1, 12'd0);
    check("l1_addr0", rd_data, 32'hFEF9_F4EF);
    do_read(3'd1, 12'd2398);
    check("l1_addr2398", rd_data, 32'h0000_CAC5);
    do_read(3'd2, 12'd669);
    check("l2_addr669", rd_data, 32'h0000_00E0);

    s_valid = 1'b1;
    s_data  = 8'h7F;
    step();
    s_valid = 1'b0;
    check("ovf_set", 32'(o_ovf), 32'd1);
    do_read(3'd2, 12'd669);
    check("l2_after_ovf", rd_data, 32'h0000_00E0);
    do_read(3'd3, 12'd0);
    check("bad_layer_valid", 32'(rd_valid), 32'd1);
    check("bad_layer_data", rd_data, 32'd0);

    user_reset = 1'b1;
    step();
    user_reset = 1'b0;
    check("clr_ovf", 32'(o_ovf), 32'd0);
    check("clr_full", 32'(o_full), 32'd0);
    check("clr_s_ready", 32'(s_ready), 32'd1);
    check("clr_empty", 32'(o_empty), 32'd1);
    do_read(3'd2, 12'd669);
    check("stale_hidden", rd_data, 32'd0);

    // Partial reload, then soft clear mid-load.
    for (int g = 0; g < 1000; g++) begin
      s_valid = 1'b1;
      s_data  = fval(g);
      step();
    end
    s_valid = 1'b0;
    check("reload_l0_ready", 32'(layer_ready), 32'b001);
    user_reset = 1'b1;
    step();
    user_reset = 1'b0;
    check("midload_clr_ready", 32'(layer_ready), 32'd0);
    check("midload_clr_empty", 32'(o_empty), 32'd1);
    do_read(3'd0, 12'd0);
    check("midload_clr_read", rd_data, 32'd0);

    for (int i = 0; i < 150; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(255 - i);
      step();
    end
    s_valid = 1'b0;
    check("rewrite_l0_ready", 32'(layer_ready), 32'b001);
    do_read(3'd0, 12'd0);
    check("rewrite_l0_addr0", rd_data, 32'hFCFD_FEFF);
    do_read(3'd1, 12'd0);
    check("rewrite_l1_zero", rd_data, 32'd0);

    rd_en    = 1'b1;
    rd_layer = 3'd0;
    rd_addr  = 12'd0;
    step();
    check("b2b_first", rd_data, 32'hFCFD_FEFF);
    rd_addr = 12'd146;
    step();
    check("b2b_second_valid", 32'(rd_valid), 32'd1);
    check("b2b_second", rd_data, 32'h6A6B_6C6D);

    // Clock-enable freeze during a write burst and a read.
    s_valid = 1'b1;
    s_data  = 8'h11;
    rd_addr = 12'd0;
    step();
    check("pre_freeze_valid", 32'(rd_valid), 32'd1);
    check("pre_freeze_data", rd_data, 32'hFCFD_FEFF);
    ce      = 1'b0;
    s_data  = 8'h22;
    rd_addr = 12'd4;
    for (int c = 0; c < 5; c++) begin
      step();
      check("freeze_valid", 32'(rd_valid), 32'd1);
      check("freeze_data", rd_data, 32'hFCFD_FEFF);
    end
    ce      = 1'b1;
    s_valid = 1'b0;
    rd_en   = 1'b0;
    step();
    check("unfreeze_valid_drop", 32'(rd_valid), 32'd0);

    for (int j = 1; j < 2400; j++) begin
      s_valid = 1'b1;
      s_data  = 8'(j);
      step();
      if (j == 2398) check("l1_refill_not_ready", 32'(layer_ready), 32'b001);
      if (j == 2399) check("l1_refill_ready", 32'(layer_ready), 32'b011);
    end
    s_valid = 1'b0;
    do_read(3'd1, 12'd0);
    check("refill_l1_addr0", rd_data, 32'h0302_0111);
    do_read(3'd1, 12'd2397);
    check("refill_l1_addr2397", rd_data, 32'h005F_5E5D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
